// File: rtl/pc_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : pc_sequencer
//  Description : Program-counter sequencer. Selects the next PC from the
//                sequential path (pc + 4) or a branch/jump/jr/trap redirect.
//                A redirect that arrives while the PC is stalled is buffered
//                (youngest wins) and applied on the first unstalled edge.
//                A saturating counter records every accepted redirect.
//                Optional feature macro: PC_TRAP_EN enables pcsrc = 100 as a
//                redirect to TRAP_VEC. Without it, pcsrc = 100 is sequential.
//  Revision    : 1.0 - initial release
// ============================================================================
module pc_sequencer #(
   parameter int            AW       = 32,
   parameter logic [AW-1:0] RESET_PC = AW'(4),
   parameter logic [AW-1:0] TRAP_VEC = AW'(32'h0000_0080),
   parameter int            CW       = 16
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          stall,
   input  logic [2:0]    pcsrc,
   input  logic          branch_bool,
   input  logic [AW-1:0] pc_branch,
   input  logic [AW-1:0] pc_jump,
   input  logic [AW-1:0] pc_jr,
   output logic [AW-1:0] pc,
   output logic [AW-1:0] pcnext,
   output logic          if_flush,
   output logic          pend_valid,
   output logic [CW-1:0] flush_cnt
);

   localparam logic [AW-1:0] c_pc_step  = AW'(4);
   localparam logic [2:0]    c_src_cond = 3'b001;
   localparam logic [2:0]    c_src_jump = 3'b010;
   localparam logic [2:0]    c_src_jr   = 3'b011;
`ifdef PC_TRAP_EN
   localparam logic [2:0]    c_src_trap = 3'b100;
`endif

   logic [AW-1:0] r_pc;
   logic [AW-1:0] r_pend_tgt;
   logic          r_pend_valid;
   logic [CW-1:0] r_flush_cnt;

   logic          w_redirect;
   logic [AW-1:0] w_redirect_tgt;
   logic [AW-1:0] w_seq_pc;
   logic          w_cnt_inc;

`ifndef PC_TRAP_EN
   // TRAP_VEC is kept in the parameter list for a uniform interface only.
   logic          w_unused_trap;
   assign w_unused_trap = ^TRAP_VEC;
`endif

   // Decode the current redirect request and its target; reserved codes fall through as sequential.
   always_comb begin
      w_redirect     = 1'b0;
      w_redirect_tgt = '0;
      case (pcsrc)
         c_src_cond: begin
            if (branch_bool) begin
               w_redirect     = 1'b1;
               w_redirect_tgt = pc_branch;
            end
         end
         c_src_jump: begin
            w_redirect     = 1'b1;
            w_redirect_tgt = pc_jump;
         end
         c_src_jr: begin
            w_redirect     = 1'b1;
            w_redirect_tgt = pc_jr;
         end
`ifdef PC_TRAP_EN
         c_src_trap: begin
            w_redirect     = 1'b1;
            w_redirect_tgt = TRAP_VEC;
         end
`endif
         default: begin
            w_redirect     = 1'b0;
            w_redirect_tgt = '0;
         end
      endcase
   end

   // Sequential target wraps naturally modulo 2^AW.
   assign w_seq_pc = r_pc + c_pc_step;

   // Next-PC select: reset value, then buffered target, then live redirect, then pc + 4.
   always_comb begin
      pcnext = w_seq_pc;
      if (!reset) begin
         pcnext = RESET_PC;
      end else if (r_pend_valid) begin
         pcnext = r_pend_tgt;
      end else if (w_redirect) begin
         pcnext = w_redirect_tgt;
      end
   end

   assign if_flush = reset & (w_redirect | r_pend_valid);

   // A redirect is counted once: when it is first accepted, either applied
   // directly or captured into the buffer. Overwrites of an already-pending
   // redirect and the later application of a buffered one do not count.
   assign w_cnt_inc = w_redirect & ~r_pend_valid;

   // PC register, redirect buffer and flush counter.
   always_ff @(posedge clk) begin
      if (!reset) begin
         r_pc         <= RESET_PC;
         r_pend_valid <= 1'b0;
         r_pend_tgt   <= '0;
         r_flush_cnt  <= '0;
      end else begin
         if (stall) begin
            if (w_redirect) begin
               r_pend_tgt   <= w_redirect_tgt;
               r_pend_valid <= 1'b1;
            end
         end else begin
            r_pc         <= pcnext;
            r_pend_valid <= 1'b0;
         end
         if (w_cnt_inc && (r_flush_cnt != {CW{1'b1}})) begin
            r_flush_cnt <= r_flush_cnt + CW'(1);
         end
      end
   end

   assign pc         = r_pc;
   assign pend_valid = r_pend_valid;
   assign flush_cnt  = r_flush_cnt;

endmodule
`default_nettype wire
